// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle (start, ctrl, a, b in; result, overflow, carry, div_zero, busy, done out)
interface seq_alu_if #(parameter int WIDTH = 16);
  logic             start;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] overflow;
  logic             carry;
  logic             div_zero;
  logic             busy;
  logic             done;
  modport master (output start, ctrl, a, b, input result, overflow, carry, div_zero, busy, done);
  modport slave (input start, ctrl, a, b, output result, overflow, carry, div_zero, busy, done);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU (add/sub/logic in one cycle, shift-add mul and restoring div over WIDTH cycles); ports clk, rst_n, bus (seq_alu_if slave)
module seq_alu #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst_n,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic             is_div;
  logic [WIDTH-1:0] rb, hi, lo, hi_n, lo_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] s_res, s_ov;
  logic             s_c, s_dz;
  logic [WIDTH:0]   sum, diff, ms, dt, dd;
  logic             accept, iterative, last, ge;
  assign accept    = bus.start && state != CALC;
  assign iterative = bus.ctrl == 3'b010 || (bus.ctrl == 3'b011 && |bus.b);
  assign last      = cnt == CW'(WIDTH - 1);
  assign bus.busy  = state == CALC;
  assign bus.done  = state == DONE;
  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};
  always_comb begin
    s_res = '0;
    s_ov  = '0;
    s_c   = 1'b0;
    s_dz  = 1'b0;
    case (bus.ctrl)
      3'b000: {s_c, s_res} = sum;
      3'b001: {s_c, s_res} = diff;
      3'b011: begin
        s_res = '1;
        s_ov  = bus.a;
        s_dz  = 1'b1;
      end
      3'b100: s_res = bus.a & bus.b;
      3'b101: s_res = bus.a | bus.b;
      3'b110: s_res = bus.a ^ bus.b;
      default: s_res = '0;
    endcase
  end
  // hi/lo hold {upper, lower} product for mul and {remainder, quotient/dividend} for div,
  // so both finish with result=lo and overflow=hi
  assign ms   = {1'b0, hi} + (lo[0] ? {1'b0, rb} : '0);
  assign dt   = {hi, lo[WIDTH-1]};
  assign ge   = dt >= {1'b0, rb};
  assign dd   = dt - {1'b0, rb};
  assign hi_n = is_div ? (ge ? dd[WIDTH-1:0] : dt[WIDTH-1:0]) : ms[WIDTH:1];
  assign lo_n = is_div ? {lo[WIDTH-2:0], ge} : {ms[0], lo[WIDTH-1:1]};
  always_comb begin
    state_n = state;
    state_n = state == CALC ? (last ? DONE : CALC) : accept ? (iterative ? CALC : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_div       <= 1'b0;
      rb           <= '0;
      hi           <= '0;
      lo           <= '0;
      cnt          <= '0;
      bus.result   <= '0;
      bus.overflow <= '0;
      bus.carry    <= 1'b0;
      bus.div_zero <= 1'b0;
    end else if (accept) begin
      is_div <= bus.ctrl[0];
      rb     <= bus.b;
      hi     <= '0;
      lo     <= bus.a;
      cnt    <= '0;
      if (!iterative) begin
        bus.result   <= s_res;
        bus.overflow <= s_ov;
        bus.carry    <= s_c;
        bus.div_zero <= s_dz;
      end
    end else if (state == CALC) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        bus.result   <= lo_n;
        bus.overflow <= hi_n;
        bus.carry    <= 1'b0;
        bus.div_zero <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=16
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int lat, bc, pulses;
  seq_alu_if #(.WIDTH(16)) bus();
  seq_alu #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] c, input logic [15:0] x, input logic [15:0] y,
                        output int l, output int b_cnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.ctrl  = c;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~x;
    bus.b     = ~y;
    l = 1;
    b_cnt = 0;
    while (!bus.done && l < 100) begin
      if (bus.busy) b_cnt++;
      @(negedge clk);
      l++;
    end
    if (!bus.done) check("timeout", 0, 1);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.ctrl  = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", bus.result, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_dz", bus.div_zero, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst_n = 1'b1;
    run_op(3'b000, 16'hFFFF, 16'h0001, lat, bc);
    check("add_lat", lat, 1);
    check("add_res", bus.result, 16'h0000);
    check("add_carry", bus.carry, 1);
    check("add_ovf", bus.overflow, 0);
    @(negedge clk);
    check("add_pulse", bus.done, 0);
    run_op(3'b001, 16'd3, 16'd5, lat, bc);
    check("sub_res", bus.result, 16'hFFFE);
    check("sub_carry", bus.carry, 1);
    run_op(3'b110, 16'hF0F0, 16'hFF00, lat, bc);
    check("xor_res", bus.result, 16'h0FF0);
    check("xor_carry", bus.carry, 0);
    run_op(3'b010, 16'hFFFF, 16'hFFFF, lat, bc);
    check("mul_busy", bc, 16);
    check("mul_lat", lat, 17);
    check("mul_res", bus.result, 16'h0001);
    check("mul_ovf", bus.overflow, 16'hFFFE);
    check("mul_carry", bus.carry, 0);
    run_op(3'b011, 16'd100, 16'd7, lat, bc);
    check("div_lat", lat, 17);
    check("div_res", bus.result, 16'd14);
    check("div_ovf", bus.overflow, 16'd2);
    check("div_dz", bus.div_zero, 0);
    run_op(3'b011, 16'd5, 16'd0, lat, bc);
    check("div0_lat", lat, 1);
    check("div0_res", bus.result, 16'hFFFF);
    check("div0_ovf", bus.overflow, 16'd5);
    check("div0_dz", bus.div_zero, 1);
    run_op(3'b111, 16'h1234, 16'h5678, lat, bc);
    check("rsv_res", bus.result, 0);
    check("rsv_ovf", bus.overflow, 0);
    check("rsv_dz", bus.div_zero, 0);
    run_op(3'b100, 16'hF0F0, 16'h3C3C, lat, bc);
    check("and_res", bus.result, 16'h3030);
    run_op(3'b101, 16'hF0F0, 16'h3C3C, lat, bc);
    check("or_res", bus.result, 16'hFCFC);
    // mul with a sub request during CALC, then a sub issued in the DONE cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.ctrl  = 3'b010;
    bus.a     = 16'h1234;
    bus.b     = 16'h0056;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    repeat (3) begin
      @(negedge clk);
      lat++;
    end
    check("hold_busy", bus.busy, 1);
    check("hold_res", bus.result, 16'hFCFC);
    bus.start = 1'b1;
    bus.ctrl  = 3'b001;
    bus.a     = 16'd10;
    bus.b     = 16'd3;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    check("ign_busy", bus.busy, 1);
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("ign_lat", lat, 17);
    check("ign_res", bus.result, 16'h1D78);
    check("ign_ovf", bus.overflow, 16'h0006);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_done", bus.done, 1);
    check("b2b_res", bus.result, 16'd7);
    check("b2b_carry", bus.carry, 0);
    // reset mid-divide
    @(negedge clk);
    bus.start = 1'b1;
    bus.ctrl  = 3'b011;
    bus.a     = 16'd1000;
    bus.b     = 16'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_res", bus.result, 0);
    check("abort_ovf", bus.overflow, 0);
    check("abort_carry", bus.carry, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("abort_pulses", pulses, 0);
    run_op(3'b000, 16'h1000, 16'h2000, lat, bc);
    check("post_lat", lat, 1);
    check("post_res", bus.result, 16'h3000);
    check("post_carry", bus.carry, 0);
    // start coincident with reset is discarded
    @(negedge clk);
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.ctrl  = 3'b000;
    bus.a     = 16'd5;
    bus.b     = 16'd6;
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    check("rs_done", bus.done, 0);
    check("rs_res", bus.result, 0);
    @(negedge clk);
    check("rs_done2", bus.done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits (legal range 4..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk only.
REQ-004 start  input  1  request; accepted when high on an edge while busy=0.
REQ-005 ctrl  input  3  opcode, sampled with start.
REQ-006 a, b  input  WIDTH  operands, sampled with start.
REQ-007 result  output  WIDTH  primary result, registered.
REQ-008 overflow  output  WIDTH  upper product half (mul), remainder (div), else 0; registered.
REQ-009 carry  output  1  carry-out (add), borrow (sub), else 0; registered.
REQ-010 div_zero  output  1  set when a divide had b=0; registered.
REQ-011 busy  output  1  high while an iterative op is in progress (state CALC).
REQ-012 done  output  1  one-cycle pulse; result/overflow/carry/div_zero valid in that cycle.

Function
REQ-013 Opcodes: 000 add, 001 sub, 010 unsigned mul, 011 unsigned div/mod, 100 and, 101 or, 110 xor, 111 reserved.
REQ-014 States: IDLE, CALC, DONE; done = (state==DONE); busy = (state==CALC).
REQ-015 Start accepted in IDLE or DONE (back-to-back allowed); start in CALC ignored, no queuing.
REQ-016 On accept, a, b, ctrl latched internally; later input changes do not affect the operation.
REQ-017 Single-cycle ops (000,001,100,101,110,111, and 011 with b=0): IDLE/DONE -> DONE; done at edge t+1 for accept at edge t.
REQ-018 Add: result = (a+b) mod 2^WIDTH, carry = bit WIDTH of the WIDTH+1-bit sum, overflow = 0.
REQ-019 Sub: result = (a-b) mod 2^WIDTH, carry = 1 iff a<b, overflow = 0.
REQ-020 Logic ops: bitwise result, carry = 0, overflow = 0; reserved 111: all outputs zero.
REQ-021 Mul: shift-add iteration, one bit per cycle, WIDTH cycles in CALC; {overflow,result} = a*b exact 2*WIDTH-bit product.
REQ-022 Div (b!=0): restoring division, one quotient bit per cycle, WIDTH cycles in CALC; result = a/b, overflow = a%b, div_zero = 0.
REQ-023 Mul/div timing: accept at edge t -> CALC at t+1, DONE at t+WIDTH+1, done high exactly one cycle.
REQ-024 Div with b=0: result = all ones, overflow = a, div_zero = 1, single-cycle path (REQ-017).
REQ-025 DONE -> IDLE after one cycle unless a new start is accepted in DONE.
REQ-026 Output registers change only on entry to DONE; hold their values through IDLE and subsequent CALC until the next DONE.
REQ-027 carry and div_zero are cleared by every completed op that does not set them.
REQ-028 Internal iteration counter is ceil(log2(WIDTH+1)) bits; no wrap occurs within one operation.

Reset
REQ-029 rst_n=0 at an edge: state=IDLE, result=0, overflow=0, carry=0, div_zero=0, busy=0, done=0, counter and operand latches cleared.
REQ-030 Reset takes priority over start and aborts any op in CALC; no done pulse is generated for the aborted op.
REQ-031 start sampled in the same edge as rst_n=0 is discarded.

Verification (WIDTH=16)
REQ-032 add a=0xFFFF, b=0x0001 -> done at t+1, result=0x0000, carry=1, overflow=0.
REQ-033 mul a=0xFFFF, b=0xFFFF -> busy for 16 cycles, done at t+17, result=0x0001, overflow=0xFFFE.
REQ-034 div a=100, b=7 -> done at t+17, result=14, overflow=2, div_zero=0; then div a=5, b=0 -> done at t+1, result=0xFFFF, overflow=5, div_zero=1.
REQ-035 mul started, start re-asserted with sub during CALC -> ignored; mul completes at t+17 with correct product; sub issued in DONE cycle completes next edge.
REQ-036 div started, rst_n=0 at t+8 -> all outputs 0, state IDLE, no done pulse; new add after reset completes normally.
REQ-037 Sub a=3, b=5 -> result=0xFFFE, carry=1; xor a=0xF0F0, b=0xFF00 -> result=0x0FF0, carry=0.
